// File: rtl/id_inst_buffer_if.sv
// Fetch-to-decode bus of the instruction buffer: fetch push channel and
// decode pop channel.
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge exactly when valid and ready are both 1 in the cycle before it.
// valid never waits on ready. Payload is only meaningful while valid = 1.
interface id_inst_buffer_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  // Environment side: fetch producer and decode consumer
  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );

  // Buffer side
  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/id_inst_buffer.sv
// Decode-front instruction buffer: circular FIFO of {pc, inst} pairs with
// load-use interlock on the head entry and a saturating stall counter.
module id_inst_buffer #(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 32,
  parameter int INST_W   = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  id_inst_buffer_if.slave          bus,
  input  logic                     flush,
  input  logic                     ex_is_load,
  input  logic [4:0]               ex_rf_waddr,
  input  logic                     mem_is_load,
  input  logic [4:0]               mem_rf_waddr,
  output logic                     stallreq_for_id,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         stall_cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     occ_q, occ_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [AW-1:0]     wr_idx, rd_idx;
  logic [4:0]        rs, rt;
  logic              empty, full, in_fire, out_fire;
  logic              hz_ex, hz_mem, hazard;

  // Status, hazard detection and next-state for pointers/occupancy/counter
  always_comb begin
    wr_idx   = wr_ptr_q[AW-1:0];
    rd_idx   = rd_ptr_q[AW-1:0];
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Both source fields are checked even for formats that ignore rt;
    // a spurious stall is safe, a missed one is not.
    rs       = inst_mem[rd_idx][25:21];
    rt       = inst_mem[rd_idx][20:16];
    hz_ex    = ex_is_load && (ex_rf_waddr != 5'd0) &&
               ((ex_rf_waddr == rs) || (ex_rf_waddr == rt));
    hz_mem   = (LOAD_LAT == 2) && mem_is_load && (mem_rf_waddr != 5'd0) &&
               ((mem_rf_waddr == rs) || (mem_rf_waddr == rt));
    hazard   = !empty && (hz_ex || hz_mem);

    in_fire  = bus.in_valid && !full;
    out_fire = !empty && !hazard && bus.out_ready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      // Redirect: drop everything, including a same-cycle push. A same-cycle
      // pop was already taken by decode, so it is simply not re-presented.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (in_fire)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (out_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + PW'(in_fire) - PW'(out_fire);
    end

    stall_d = stall_q;
    if (hazard && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
  end

  // Control state: async clear drops all entries immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      stall_q  <= stall_d;
    end
  end

  // Entry storage: no reset, contents only observed behind valid pointers
  always_ff @(posedge clk) begin
    if (in_fire && !flush) begin
      pc_mem[wr_idx]   <= bus.in_pc;
      inst_mem[wr_idx] <= bus.in_inst;
    end
  end

  assign bus.in_ready     = !full;
  assign bus.out_valid    = !empty && !hazard;
  assign bus.out_pc       = pc_mem[rd_idx];
  assign bus.out_inst     = inst_mem[rd_idx];
  assign stallreq_for_id  = hazard;
  assign occupancy        = occ_q;
  assign stall_cycles     = stall_q;
endmodule

// File: tb/tb_id_inst_buffer.sv
// Bench for id_inst_buffer. Two builds run side by side on shared stimulus:
// dut_a (LOAD_LAT=1, CNT_W=4) and dut_b (LOAD_LAT=2, CNT_W=16). A queue
// model per build predicts every output each cycle.
module tb_id_inst_buffer;
  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        in_valid, out_ready, flush;
  logic [31:0] in_pc, in_inst;
  logic        ex_is_load, mem_is_load;
  logic [4:0]  ex_rf_waddr, mem_rf_waddr;
  logic        stall_a, stall_b;
  logic [2:0]  occ_a, occ_b;
  logic [3:0]  sc_a;
  logic [15:0] sc_b;

  int          checks;
  int          failures;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  int unsigned cnt0, cnt1;

  id_inst_buffer_if #(.PC_W(32), .INST_W(32)) ifa ();
  id_inst_buffer_if #(.PC_W(32), .INST_W(32)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_pc     = in_pc;
  assign ifa.in_inst   = in_inst;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_pc     = in_pc;
  assign ifb.in_inst   = in_inst;
  assign ifb.out_ready = out_ready;

  id_inst_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .LOAD_LAT(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .flush(flush),
    .ex_is_load(ex_is_load), .ex_rf_waddr(ex_rf_waddr),
    .mem_is_load(mem_is_load), .mem_rf_waddr(mem_rf_waddr),
    .stallreq_for_id(stall_a), .occupancy(occ_a), .stall_cycles(sc_a)
  );

  id_inst_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .LOAD_LAT(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .flush(flush),
    .ex_is_load(ex_is_load), .ex_rf_waddr(ex_rf_waddr),
    .mem_is_load(mem_is_load), .mem_rf_waddr(mem_rf_waddr),
    .stallreq_for_id(stall_b), .occupancy(occ_b), .stall_cycles(sc_b)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: a load in EX (or MEM for the two-stage build) writing a
  // nonzero register that the head reads as rs or rt blocks the head.
  function automatic bit model_hz(input int k, input logic [31:0] inst);
    logic [4:0] rs, rt;
    bit hex, hmem;
    rs   = inst[25:21];
    rt   = inst[20:16];
    hex  = ex_is_load && (ex_rf_waddr != 0) && (ex_rf_waddr == rs || ex_rf_waddr == rt);
    hmem = (k == 1) && mem_is_load && (mem_rf_waddr != 0) &&
           (mem_rf_waddr == rs || mem_rf_waddr == rt);
    return hex || hmem;
  endfunction

  task automatic check_dut(input int k, input logic [63:0] q[$], input int unsigned cnt,
                           input logic ir, input logic ov, input logic hz,
                           input logic [63:0] head, input logic [2:0] occ,
                           input logic [15:0] sc);
    bit ne, e_hz;
    logic [63:0] e_head;
    string p;
    p      = (k == 0) ? "a" : "b";
    ne     = (q.size() != 0);
    e_head = ne ? q[0] : 64'd0;
    e_hz   = ne && model_hz(k, e_head[31:0]);
    chk({p, "_in_ready"}, ir, q.size() != DEPTH);
    chk({p, "_out_valid"}, ov, ne && !e_hz);
    chk({p, "_stallreq"}, hz, e_hz);
    chk({p, "_occupancy"}, occ, q.size());
    chk({p, "_stall_cycles"}, sc, cnt);
    if (ne && !e_hz) chk({p, "_head"}, head, e_head);
  endtask

  // Model of one clock edge for one build, using the inputs of this cycle
  task automatic adv(input int k, input int unsigned maxc,
                     inout logic [63:0] q[$], inout int unsigned cnt);
    bit ne, hz, ifire, ofire;
    if (!rst_n) begin
      q.delete();
      cnt = 0;
    end else begin
      ne    = (q.size() != 0);
      hz    = ne && model_hz(k, q[0][31:0]);
      ifire = in_valid && (q.size() < DEPTH);
      ofire = ne && !hz && out_ready;
      if (hz && cnt < maxc) cnt++;
      if (flush) q.delete();
      else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back({in_pc, in_inst});
      end
    end
  endtask

  // One cycle: check mid-cycle, advance model, land 1 time unit after the edge
  task automatic step();
    @(negedge clk);
    check_dut(0, q0, cnt0, ifa.in_ready, ifa.out_valid, stall_a,
              {ifa.out_pc, ifa.out_inst}, occ_a, {12'd0, sc_a});
    check_dut(1, q1, cnt1, ifb.in_ready, ifb.out_valid, stall_b,
              {ifb.out_pc, ifb.out_inst}, occ_b, sc_b);
    adv(0, 15, q0, cnt0);
    adv(1, 65535, q1, cnt1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
  endtask

  // Scoreboard-driven directed and random sequence
  initial begin
    checks = 0; failures = 0; cnt0 = 0; cnt1 = 0;
    rst_n = 1'b0; flush = 1'b0;
    ex_is_load = 1'b0; ex_rf_waddr = 5'd0;
    mem_is_load = 1'b0; mem_rf_waddr = 5'd0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Fill to full with decode stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), {6'd0, 5'(i + 8), 5'(i + 12), 16'($urandom)}, 1'b0);
      step();
    end
    drive(1'b1, 32'h100, 32'h0, 1'b0);
    step();
    chk("full_in_ready", ifa.in_ready, 1'b0);
    chk("full_occ", occ_a, 3'd4);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) step();
    chk("drained_out_valid", ifa.out_valid, 1'b0);

    // Wrap-around: continuous push and pop
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), {6'd0, 5'd9, 5'd10, 16'($urandom)}, 1'b1);
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    step(); step();

    // Load-use on rs: addu $3,$2,$4 with load to $2 in EX
    drive(1'b1, 32'h2000, 32'h00441821, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    ex_is_load = 1'b1; ex_rf_waddr = 5'd2;
    step(); step(); step();
    chk("lu_stallreq", stall_a, 1'b1);
    chk("lu_out_valid", ifa.out_valid, 1'b0);
    ex_is_load = 1'b0;
    step();
    // Register 0 never matches: rs = 0, load targets $0
    ex_is_load = 1'b1; ex_rf_waddr = 5'd0;
    drive(1'b1, 32'h2004, 32'h00041821, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    step();
    chk("r0_out_valid", ifa.out_valid, 1'b1);
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    ex_is_load = 1'b0;

    // MEM-stage load to $4: stalls only the two-stage build
    drive(1'b1, 32'h3000, 32'h00441821, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    mem_is_load = 1'b1; mem_rf_waddr = 5'd4;
    step();
    chk("mem_a_stall", stall_a, 1'b0);
    chk("mem_b_stall", stall_b, 1'b1);
    step(); step();
    mem_is_load = 1'b0;
    step(); step();

    // Flush at occupancy 3 with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4000 + 32'(i * 4), {6'd0, 5'd5, 5'd6, 16'(i)}, 1'b0);
      step();
    end
    drive(1'b1, 32'h4FFC, 32'h00A6BEEF, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    chk("flush_occ", occ_a, 3'd0);
    chk("flush_out_valid", ifa.out_valid, 1'b0);
    step(); step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom,
            {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)},
            1'($urandom_range(0, 1)));
      flush        = ($urandom_range(0, 15) == 0);
      ex_is_load   = 1'($urandom_range(0, 1));
      ex_rf_waddr  = 5'($urandom_range(0, 7));
      mem_is_load  = 1'($urandom_range(0, 1));
      mem_rf_waddr = 5'($urandom_range(0, 7));
      step();
    end
    flush = 1'b0; ex_is_load = 1'b0; mem_is_load = 1'b0;

    // Asynchronous reset mid-cycle with two entries held
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 32'h5000, 32'h0, 1'b0);
    step();
    drive(1'b1, 32'h5004, 32'h0, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    chk("pre_rst_occ", occ_a, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", occ_a, 3'd0);
    chk("arst_in_ready", ifa.in_ready, 1'b1);
    chk("arst_out_valid", ifa.out_valid, 1'b0);
    chk("arst_stallreq", stall_a, 1'b0);
    chk("arst_stall_cycles", sc_a, 4'd0);
    q0.delete(); q1.delete(); cnt0 = 0; cnt1 = 0;
    step();
    rst_n = 1'b1;
    step();

    // Counter saturation: hold a hazard for 20 cycles on the 4-bit build
    drive(1'b1, 32'h6000, 32'h00441821, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b1);
    ex_is_load = 1'b1; ex_rf_waddr = 5'd4;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cycles", sc_a, 4'd15);
    ex_is_load = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_inst_buffer.md
Name: id_inst_buffer

Overview:
- Parametrised decode-front buffer between IF and ID, replacing ad-hoc single-register instruction hold logic.
- Queues {pc, inst} pairs from fetch in a DEPTH-entry circular FIFO and presents the head to decode via valid/ready.
- Performs load-use interlock against up to two load-producing stages, with a saturating stall-cycle counter.
- Flushed wholesale on branch redirect.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
PC_W, 32, pc width
INST_W, 32, instruction width (rs = inst[25:21], rt = inst[20:16])
LOAD_LAT, 1, load-use distance checked: 1 = EX only, 2 = EX and MEM
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  fetch pair valid
in_ready  out  1  buffer can accept
in_pc  in  PC_W  fetch pc
in_inst  in  INST_W  fetched instruction
out_valid  out  1  head available and hazard-free
out_ready  in  1  decode accepts head
out_pc  out  PC_W  head pc
out_inst  out  INST_W  head instruction
flush  in  1  discard all entries (branch redirect)
ex_is_load  in  1  EX-stage instruction is a load
ex_rf_waddr  in  5  EX-stage destination register
mem_is_load  in  1  MEM-stage instruction is a load (used only if LOAD_LAT=2)
mem_rf_waddr  in  5  MEM-stage destination register
stallreq_for_id  out  1  interlock active on head
occupancy  out  log2(DEPTH)+1  valid entries
stall_cycles  out  CNT_W  saturating interlock-cycle count

Behaviour:
- Reset (rst_n low, async):
  - wr_ptr, rd_ptr, occupancy, stall_cycles = 0.
  - in_ready = 1; out_valid = 0; stallreq_for_id = 0.
  - Entry storage need not be reset.
  - out_pc/out_inst are don't-care while out_valid = 0.
  - Reset asserted mid-operation drops all entries immediately.
- Pointers:
  - log2(DEPTH)+1 bits; MSB distinguishes full from empty.
  - empty = ptrs equal; full = low bits equal and MSBs differ.
  - Wrap-around is modulo 2*DEPTH.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !full. No same-cycle pass-through when full.
  - Write latency: an entry written at edge N is at the head no earlier than cycle N+1. No combinational in->out bypass.
  - in_fire and out_fire in the same cycle: both take effect; occupancy unchanged. This is legal at full only if in_ready was 1, so never at full.
- Hazard (combinational on head):
  - hz_ex = ex_is_load & ex_rf_waddr != 0 & (ex_rf_waddr == rs | ex_rf_waddr == rt).
  - hz_mem = (LOAD_LAT == 2) & mem_is_load & mem_rf_waddr != 0 & (mem_rf_waddr == rs | mem_rf_waddr == rt).
  - hazard = !empty & (hz_ex | hz_mem).
  - out_valid = !empty & !hazard; stallreq_for_id = hazard.
  - Both rs and rt are compared unconditionally (conservative). Register 0 never matches.
- Flush:
  - At the edge where flush = 1: wr_ptr = rd_ptr = 0 and occupancy = 0.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle counts as consumed by decode (delay slot); the buffer does not re-present it.
  - Flush while empty is a no-op apart from pointer clear.
- Stall counter:
  - +1 on each cycle with stallreq_for_id = 1, including flush cycles.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- occupancy is registered and equals entries stored (0..DEPTH).

Test Plan:
- Reset then push 4 pairs (pc 0x00,0x04,0x08,0x0C), out_ready = 0 -> occupancy = 4, in_ready = 0 after 4th edge; then out_ready = 1 -> heads pop in order 0x00..0x0C one per cycle, out_valid drops after 4 pops.
- Wrap-around: 10 pushes with continuous pop at 1/cycle -> outputs match input order; occupancy stays at 1 in steady state.
- Load-use: head inst = addu $3,$2,$4 (0x00441821), ex_is_load = 1, ex_rf_waddr = 2 -> out_valid = 0, stallreq_for_id = 1, stall_cycles increments; drop ex_is_load -> out_valid = 1 next cycle. Repeat with ex_rf_waddr = 0 and rs = 0 -> no stall.
- LOAD_LAT = 2 build: mem_is_load = 1, mem_rf_waddr = 4 with the same head -> stall. LOAD_LAT = 1 build with the same stimulus -> no stall.
- Flush with occupancy = 3 and a simultaneous in_fire and out_fire -> occupancy = 0 next cycle, out_valid = 0; the pushed pair never appears at the head.
- Async reset: drop rst_n mid-cycle with occupancy = 2 -> outputs go to reset values before the next edge. Counter saturation (CNT_W = 4, hold hazard 20 cycles) -> stall_cycles = 15.
